// File: rtl/data_ram_access.sv
// Data-memory stage: one LDR/STR at a time on an internal word RAM with a fixed
// wait-state count. Returns read data with a one-cycle pulse and flags bad addresses.
module data_ram_access #(
  parameter int ADDR_BITS   = 8,
  parameter int WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_rw,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        busy,
  output logic        rd_valid,
  output logic [31:0] rd_data,
  output logic        err
);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] ACCESS = 1'b1;

  typedef struct packed {
    logic        rw;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  req_t                 req_q;
  logic [0:0]           state;
  logic [3:0]           cnt;
  logic                 bad;
  logic                 done;
  logic [ADDR_BITS-1:0] idx;

  logic [31:0] mem [0:(2**ADDR_BITS)-1];

  assign bad  = (req_q.addr[1:0] != 2'b00) || (req_q.addr[31:ADDR_BITS+2] != '0);
  assign idx  = req_q.addr[ADDR_BITS+1:2];
  assign done = (state == ACCESS) && (cnt == 4'd0);
  assign busy = (state == ACCESS);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      rd_valid <= 1'b0;
      err      <= 1'b0;
      rd_data  <= 32'd0;
      req_q    <= '0;
    end else begin
      rd_valid <= 1'b0;
      err      <= 1'b0;
      if (state == IDLE) begin
        // Latch the whole request so upstream is free to move on next cycle.
        if (req_valid) begin
          req_q <= '{rw: req_rw, addr: req_addr, wdata: req_wdata};
          cnt   <= 4'(WAIT_STATES);
          state <= ACCESS;
        end
      end else begin
        if (cnt != 4'd0) begin
          cnt <= cnt - 4'd1;
        end else begin
          state <= IDLE;
          if (bad) begin
            err <= 1'b1;
          end else if (req_q.rw) begin
            rd_data  <= mem[idx];
            rd_valid <= 1'b1;
          end
        end
      end
    end
  end

  // RAM is not reset; a reset during an access suppresses the write.
  always_ff @(posedge clk) begin
    if (!rst && done && !bad && !req_q.rw)
      mem[idx] <= req_q.wdata;
  end

endmodule

// File: tb/tb_data_ram_access.sv
// Directed bench for data_ram_access: WAIT_STATES=2 instance for most steps,
// a WAIT_STATES=0 instance for back-to-back throughput.
module tb_data_ram_access;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_rw;
  logic [31:0] req_addr, req_wdata;
  logic        busy, rd_valid, err;
  logic [31:0] rd_data;

  logic        v0, rw0;
  logic [31:0] a0, wd0;
  logic        busy0, rd_valid0, err0;
  logic [31:0] rd_data0;

  int vectors     = 0;
  int miscompares = 0;
  int pulses;

  always #5 clk = ~clk;

  data_ram_access #(.ADDR_BITS(8), .WAIT_STATES(2)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_rw(req_rw),
    .req_addr(req_addr), .req_wdata(req_wdata), .busy(busy),
    .rd_valid(rd_valid), .rd_data(rd_data), .err(err)
  );

  data_ram_access #(.ADDR_BITS(8), .WAIT_STATES(0)) dut0 (
    .clk(clk), .rst(rst), .req_valid(v0), .req_rw(rw0),
    .req_addr(a0), .req_wdata(wd0), .busy(busy0),
    .rd_valid(rd_valid0), .rd_data(rd_data0), .err(err0)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Full WAIT_STATES=2 access: accept, three busy cycles, completion, pulse drop.
  task automatic do_access(input string tag, input logic rw, input logic [31:0] addr,
                           input logic [31:0] wd, input logic exp_err,
                           input logic exp_rdv, input logic [31:0] exp_rd);
    req_valid = 1'b1; req_rw = rw; req_addr = addr; req_wdata = wd;
    step();
    chk({tag, "_busy_T"}, 32'(busy), 32'd1);
    req_valid = 1'b0; req_rw = ~rw; req_addr = 32'hFFFF_FFFC; req_wdata = 32'h0;
    step();
    chk({tag, "_busy_T1"}, 32'(busy), 32'd1);
    chk({tag, "_rdv_T1"}, 32'(rd_valid | err), 32'd0);
    step();
    chk({tag, "_busy_T2"}, 32'(busy), 32'd1);
    step();
    chk({tag, "_busy_C"}, 32'(busy), 32'd0);
    chk({tag, "_err_C"}, 32'(err), 32'(exp_err));
    chk({tag, "_rdv_C"}, 32'(rd_valid), 32'(exp_rdv));
    chk({tag, "_rdata_C"}, rd_data, exp_rd);
    step();
    chk({tag, "_pulse_end"}, 32'(rd_valid | err), 32'd0);
  endtask

  task automatic w0(input logic [31:0] addr, input logic [31:0] data);
    v0 = 1'b1; rw0 = 1'b0; a0 = addr; wd0 = data;
    step();
    chk("w0_busy", 32'(busy0), 32'd1);
    v0 = 1'b0;
    step();
    chk("w0_done", {29'd0, busy0, rd_valid0, err0}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_rw = 1'b0; req_addr = 0; req_wdata = 0;
    v0 = 1'b0; rw0 = 1'b0; a0 = 0; wd0 = 0;
    step(); step();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rdv", 32'(rd_valid), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_rdata", rd_data, 32'd0);
    rst = 1'b0;

    do_access("init0",  1'b0, 32'h00, 32'hA5A5_0000, 1'b0, 1'b0, 32'd0);
    do_access("init4",  1'b0, 32'h04, 32'h0000_1111, 1'b0, 1'b0, 32'd0);
    do_access("init20", 1'b0, 32'h20, 32'h55AA_55AA, 1'b0, 1'b0, 32'd0);

    // Write then read back
    do_access("t1w", 1'b0, 32'h10, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'd0);
    do_access("t1r", 1'b1, 32'h10, 32'h0, 1'b0, 1'b1, 32'hDEAD_BEEF);

    // Misaligned and out-of-range; 0x400 aliases index 0 if range check is missing
    do_access("t2mis", 1'b1, 32'h13, 32'h0, 1'b1, 1'b0, 32'hDEAD_BEEF);
    do_access("t2oor", 1'b0, 32'h400, 32'hBAD0_BAD0, 1'b1, 1'b0, 32'hDEAD_BEEF);
    do_access("t2r0", 1'b1, 32'h00, 32'h0, 1'b0, 1'b1, 32'hA5A5_0000);

    // New request held while busy must be ignored
    req_valid = 1'b1; req_rw = 1'b1; req_addr = 32'h10; req_wdata = 0;
    step();
    chk("t3_busy_T", 32'(busy), 32'd1);
    req_rw = 1'b0; req_addr = 32'h04; req_wdata = 32'hFFFF_FFFF;
    pulses = 0;
    step(); pulses += int'(rd_valid);
    step(); pulses += int'(rd_valid);
    step(); pulses += int'(rd_valid);
    chk("t3_rdv_C", 32'(rd_valid), 32'd1);
    chk("t3_rdata_C", rd_data, 32'hDEAD_BEEF);
    req_valid = 1'b0;
    step(); pulses += int'(rd_valid);
    chk("t3_idle", 32'(busy), 32'd0);
    chk("t3_pulses", 32'(pulses), 32'd1);
    do_access("t3r4", 1'b1, 32'h04, 32'h0, 1'b0, 1'b1, 32'h0000_1111);

    // Reset aborts an in-flight write
    req_valid = 1'b1; req_rw = 1'b0; req_addr = 32'h20; req_wdata = 32'h1234_5678;
    step();
    chk("t4_busy_T", 32'(busy), 32'd1);
    req_valid = 1'b0; rst = 1'b1;
    step();
    chk("t4_busy_rst", 32'(busy), 32'd0);
    rst = 1'b0;
    pulses = 0;
    repeat (4) begin
      step();
      pulses += int'(rd_valid) + int'(err) + int'(busy);
    end
    chk("t4_no_pulse", 32'(pulses), 32'd0);
    chk("t4_rdata_rst", rd_data, 32'd0);
    do_access("t4r", 1'b1, 32'h20, 32'h0, 1'b0, 1'b1, 32'h55AA_55AA);

    // Reset held with req_valid high
    rst = 1'b1; req_valid = 1'b1; req_rw = 1'b1; req_addr = 32'h10;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t6_outs", {29'd0, busy, rd_valid, err}, 32'd0);
      chk("t6_rdata", rd_data, 32'd0);
    end
    rst = 1'b0; req_valid = 1'b0;
    step();
    chk("t6_idle", 32'(busy), 32'd0);

    // WAIT_STATES=0: back-to-back reads with req_valid held
    w0(32'h00, 32'h1111_0000);
    w0(32'h04, 32'h2222_0004);
    v0 = 1'b1; rw0 = 1'b1; a0 = 32'h00;
    step();
    chk("t5_busy_T", 32'(busy0), 32'd1);
    a0 = 32'h04;
    step();
    chk("t5_rdv_T1", 32'(rd_valid0), 32'd1);
    chk("t5_rdata_T1", rd_data0, 32'h1111_0000);
    chk("t5_busy_T1", 32'(busy0), 32'd0);
    step();
    chk("t5_busy_T2", 32'(busy0), 32'd1);
    chk("t5_rdv_T2", 32'(rd_valid0), 32'd0);
    v0 = 1'b0;
    step();
    chk("t5_rdv_T3", 32'(rd_valid0), 32'd1);
    chk("t5_rdata_T3", rd_data0, 32'h2222_0004);
    step();
    chk("t5_end", {29'd0, busy0, rd_valid0, err0}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
